// File: rtl/axi4_lite_write_slave_responder.sv
// AXI4-Lite write-channel subordinate: collects one AW and one W beat, decodes the
// address window, commits byte-enabled data to a local register file, then answers on B.
module axi4_lite_write_slave_responder #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter int                         REG_COUNT     = 16,
    parameter logic [ADDRESS_WIDTH-1:0]   MIN_ADDRESS   = 32'h0000_0000,
    parameter logic [ADDRESS_WIDTH-1:0]   MAX_ADDRESS   = 32'h0000_003F,
    parameter int                         DELAY_WIDTH   = 5
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          awvalid,
    output logic                          awready,
    input  logic [ADDRESS_WIDTH-1:0]      awaddr,
    input  logic [2:0]                    awprot,
    input  logic                          wvalid,
    output logic                          wready,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [DATA_WIDTH/8-1:0]       wstrb,
    output logic                          bvalid,
    input  logic                          bready,
    output logic [1:0]                    bresp,
    input  logic [DELAY_WIDTH-1:0]        bvalidDelay,
    input  logic [$clog2(REG_COUNT)-1:0]  dbgIndex,
    output logic [DATA_WIDTH-1:0]         dbgData,
    output logic [2:0]                    lastAwprot,
    output logic [15:0]                   writeCount
);

    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int ADDR_LSB    = $clog2(STRB_WIDTH);
    localparam int INDEX_WIDTH = $clog2(REG_COUNT);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_DELAY   = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [1:0]               state;
    logic                     aw_captured;
    logic                     w_captured;
    logic [ADDRESS_WIDTH-1:0] aw_addr_q;
    logic [2:0]               aw_prot_q;
    logic [DATA_WIDTH-1:0]    w_data_q;
    logic [STRB_WIDTH-1:0]    w_strb_q;
    logic [DELAY_WIDTH-1:0]   delay_cnt;
    logic [DATA_WIDTH-1:0]    regs [REG_COUNT];

    logic                     aw_hs;
    logic                     w_hs;
    logic [1:0]               decode_resp;
    logic [INDEX_WIDTH-1:0]   decode_index;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Out-of-window addresses take priority over misalignment.
    always_comb begin
        decode_resp = RESP_OKAY;
        if (aw_addr_q < MIN_ADDRESS || aw_addr_q > MAX_ADDRESS) begin
            decode_resp = RESP_DECERR;
        end else if (aw_addr_q[ADDR_LSB-1:0] != '0) begin
            decode_resp = RESP_SLVERR;
        end
    end

    assign decode_index = INDEX_WIDTH'((aw_addr_q - MIN_ADDRESS) >> ADDR_LSB);
    assign dbgData      = regs[dbgIndex];

    always_ff @(posedge aclk) begin
        if (areset) begin
            state       <= ST_COLLECT;
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
            aw_addr_q   <= '0;
            aw_prot_q   <= '0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            delay_cnt   <= '0;
            awready     <= 1'b0;
            wready      <= 1'b0;
            bvalid      <= 1'b0;
            bresp       <= RESP_OKAY;
            lastAwprot  <= '0;
            writeCount  <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (aw_captured && w_captured) begin
                        bresp     <= decode_resp;
                        delay_cnt <= bvalidDelay;
                        state     <= (bvalidDelay == '0) ? ST_RESP : ST_DELAY;
                        if (decode_resp == RESP_OKAY) begin
                            lastAwprot <= aw_prot_q;
                            for (int b = 0; b < STRB_WIDTH; b++) begin
                                if (w_strb_q[b]) begin
                                    regs[decode_index][b*8 +: 8] <= w_data_q[b*8 +: 8];
                                end
                            end
                        end
                    end else begin
                        if (aw_hs) begin
                            aw_captured <= 1'b1;
                            aw_addr_q   <= awaddr;
                            aw_prot_q   <= awprot;
                        end
                        if (w_hs) begin
                            w_captured <= 1'b1;
                            w_data_q   <= wdata;
                            w_strb_q   <= wstrb;
                        end
                        awready <= !(aw_captured || aw_hs);
                        wready  <= !(w_captured || w_hs);
                    end
                end

                ST_DELAY: begin
                    delay_cnt <= delay_cnt - 1'b1;
                    if (delay_cnt == DELAY_WIDTH'(1)) begin
                        state <= ST_RESP;
                    end
                end

                // bvalid rises one cycle after entering RESP, then holds until bready.
                ST_RESP: begin
                    if (!bvalid) begin
                        bvalid <= 1'b1;
                    end else if (bready) begin
                        bvalid      <= 1'b0;
                        aw_captured <= 1'b0;
                        w_captured  <= 1'b0;
                        awready     <= 1'b1;
                        wready      <= 1'b1;
                        state       <= ST_COLLECT;
                        if (bresp == RESP_OKAY) begin
                            writeCount <= writeCount + 16'd1;
                        end
                    end
                end

                default: begin
                    state <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_write_slave_responder.sv
// Bench for axi4_lite_write_slave_responder: directed transactions plus a transaction-level
// reference model compared against the DUT outputs on every cycle.
module tb_axi4_lite_write_slave_responder;

    localparam logic [31:0] MIN_ADDR = 32'h0000_0000;
    localparam logic [31:0] MAX_ADDR = 32'h0000_003F;

    logic        aclk = 1'b0;
    logic        areset;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [4:0]  bvalidDelay;
    logic [3:0]  dbgIndex;
    logic [31:0] dbgData;
    logic [2:0]  lastAwprot;
    logic [15:0] writeCount;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    axi4_lite_write_slave_responder dut (
        .aclk        (aclk),
        .areset      (areset),
        .awvalid     (awvalid),
        .awready     (awready),
        .awaddr      (awaddr),
        .awprot      (awprot),
        .wvalid      (wvalid),
        .wready      (wready),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .bvalid      (bvalid),
        .bready      (bready),
        .bresp       (bresp),
        .bvalidDelay (bvalidDelay),
        .dbgIndex    (dbgIndex),
        .dbgData     (dbgData),
        .lastAwprot  (lastAwprot),
        .writeCount  (writeCount)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
        end
    endtask

    // Reference model: one outstanding transaction tracked by flags and cycle stamps.
    bit          m_valid = 0;
    bit          m_just_reset;
    bit          m_aw_have;
    bit          m_w_have;
    bit          m_committed;
    int          m_bvalid_from;
    logic [31:0] m_addr;
    logic [2:0]  m_prot;
    logic [31:0] m_data;
    logic [3:0]  m_strb;
    logic [1:0]  m_bresp;
    logic [2:0]  m_last_prot;
    logic [15:0] m_count;
    logic [31:0] m_regs [16];
    logic        e_awready;
    logic        e_wready;
    logic        e_bvalid;
    int          m_idx;

    always @(negedge aclk) begin
        if (m_valid) begin
            e_awready = !m_just_reset && !m_committed && !m_aw_have;
            e_wready  = !m_just_reset && !m_committed && !m_w_have;
            e_bvalid  = m_committed && (cyc >= m_bvalid_from);
            checkOutput("awready", awready, e_awready);
            checkOutput("wready", wready, e_wready);
            checkOutput("bvalid", bvalid, e_bvalid);
            if (e_bvalid || m_just_reset) checkOutput("bresp", bresp, m_bresp);
            checkOutput("writeCount", writeCount, m_count);
            checkOutput("lastAwprot", lastAwprot, m_last_prot);
            checkOutput("dbgData", dbgData, m_regs[dbgIndex]);
        end
        if (areset) begin
            m_valid      = 1;
            m_just_reset = 1;
            m_aw_have    = 0;
            m_w_have     = 0;
            m_committed  = 0;
            m_bvalid_from = 0;
            m_bresp      = 2'b00;
            m_last_prot  = 3'b000;
            m_count      = 16'd0;
            for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        end else if (m_valid) begin
            if (e_bvalid && bready) begin
                if (m_bresp == 2'b00) m_count = m_count + 16'd1;
                m_aw_have   = 0;
                m_w_have    = 0;
                m_committed = 0;
            end else if (m_aw_have && m_w_have && !m_committed) begin
                m_committed   = 1;
                m_bvalid_from = cyc + 2 + int'(bvalidDelay);
                if (m_addr < MIN_ADDR || m_addr > MAX_ADDR) begin
                    m_bresp = 2'b11;
                end else if (m_addr % 4 != 0) begin
                    m_bresp = 2'b10;
                end else begin
                    m_bresp     = 2'b00;
                    m_last_prot = m_prot;
                    m_idx       = int'((m_addr - MIN_ADDR) / 4);
                    for (int b = 0; b < 4; b++)
                        if (m_strb[b]) m_regs[m_idx][8*b +: 8] = m_data[8*b +: 8];
                end
            end
            if (e_awready && awvalid) begin
                m_aw_have = 1;
                m_addr    = awaddr;
                m_prot    = awprot;
            end
            if (e_wready && wvalid) begin
                m_w_have = 1;
                m_data   = wdata;
                m_strb   = wstrb;
            end
            m_just_reset = 0;
        end
    end

    // Presents W, then AW w_lead cycles later (0 = together); returns the edge of the last handshake.
    task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] prot, input logic [31:0] data,
                                 input logic [3:0] strb, input logic [4:0] dly, input int w_lead,
                                 output int last_edge);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_seen;
        bit w_seen;
        int t = 0;
        last_edge = -1;
        @(posedge aclk); #1;
        bvalidDelay = dly;
        awaddr = addr; awprot = prot;
        wdata = data; wstrb = strb;
        wvalid  = 1'b1;
        awvalid = (w_lead == 0);
        while (!(aw_done && w_done) && t < 50) begin
            @(negedge aclk);
            if (w_done && !aw_done) checkOutput("wready_after_w", wready, 1'b0);
            if (aw_done && !w_done) checkOutput("awready_after_aw", awready, 1'b0);
            aw_seen = awvalid && awready;
            w_seen  = wvalid && wready;
            @(posedge aclk); #1;
            t++;
            if (aw_seen) begin aw_done = 1; awvalid = 1'b0; last_edge = cyc; end
            if (w_seen)  begin w_done = 1;  wvalid = 1'b0;  last_edge = cyc; end
            if (!aw_done && !awvalid && t >= w_lead) awvalid = 1'b1;
        end
        if (!(aw_done && w_done)) begin
            checkOutput("handshake_timeout", {62'd0, aw_done, w_done}, 64'd3);
            awvalid = 1'b0;
            wvalid  = 1'b0;
        end
    endtask

    // Waits for bvalid, holds bready low for 'hold' cycles, completes B, checks readies return.
    task automatic waitResponse(input int hold, input logic [1:0] exp_resp, output int bv_edge);
        int t = 0;
        bv_edge = -1;
        @(negedge aclk);
        while (bvalid !== 1'b1 && t < 100) begin
            @(negedge aclk);
            t++;
        end
        if (bvalid !== 1'b1) begin
            checkOutput("bvalid_timeout", bvalid, 1'b1);
            return;
        end
        bv_edge = cyc;
        checkOutput("bresp_first", bresp, exp_resp);
        for (int i = 0; i < hold; i++) begin
            @(posedge aclk); #1;
            @(negedge aclk);
            checkOutput("hold_bvalid", bvalid, 1'b1);
            checkOutput("hold_bresp", bresp, exp_resp);
            checkOutput("hold_awready", awready, 1'b0);
            checkOutput("hold_wready", wready, 1'b0);
        end
        @(posedge aclk); #1;
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        @(negedge aclk);
        checkOutput("post_b_awready", awready, 1'b1);
        checkOutput("post_b_wready", wready, 1'b1);
        checkOutput("post_b_bvalid", bvalid, 1'b0);
    endtask

    task automatic setIndex(input logic [3:0] idx);
        @(posedge aclk); #1;
        dbgIndex = idx;
        @(negedge aclk);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t_last;
        int bv;
        int seen;
        areset = 1'b1;
        awvalid = 1'b0; awaddr = '0; awprot = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0;
        bready = 1'b0; bvalidDelay = '0; dbgIndex = '0;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;

        @(negedge aclk);
        checkOutput("reset_awready", awready, 1'b0);
        checkOutput("reset_wready", wready, 1'b0);
        checkOutput("reset_bvalid", bvalid, 1'b0);
        checkOutput("reset_bresp", bresp, 2'b00);
        checkOutput("reset_writeCount", writeCount, 16'd0);
        checkOutput("reset_lastAwprot", lastAwprot, 3'd0);
        checkOutput("reset_dbgData", dbgData, 32'h0);
        @(negedge aclk);
        checkOutput("release_awready", awready, 1'b1);
        checkOutput("release_wready", wready, 1'b1);

        $display("[TB] single write, same-edge AW/W, zero delay");
        applyStimulus(32'h08, 3'b001, 32'hDEADBEEF, 4'hF, 5'd0, 0, t_last);
        waitResponse(0, 2'b00, bv);
        checkOutput("single_latency", bv - t_last, 2);
        setIndex(4'd2);
        checkOutput("single_reg2", dbgData, 32'hDEADBEEF);
        checkOutput("single_count", writeCount, 16'd1);

        $display("[TB] W three cycles ahead of AW, delay 4");
        applyStimulus(32'h04, 3'b010, 32'h11223344, 4'hF, 5'd4, 3, t_last);
        waitResponse(0, 2'b00, bv);
        checkOutput("indep_latency", bv - t_last, 6);
        setIndex(4'd1);
        checkOutput("indep_reg1", dbgData, 32'h11223344);
        checkOutput("indep_count", writeCount, 16'd2);

        $display("[TB] byte strobes");
        applyStimulus(32'h00, 3'b011, 32'hAAAAAAAA, 4'hF, 5'd1, 0, t_last);
        waitResponse(0, 2'b00, bv);
        checkOutput("strb_delay1_latency", bv - t_last, 3);
        applyStimulus(32'h00, 3'b011, 32'h55667788, 4'b0101, 5'd0, 0, t_last);
        waitResponse(0, 2'b00, bv);
        setIndex(4'd0);
        checkOutput("strb_merge", dbgData, 32'hAA66AA88);
        applyStimulus(32'h00, 3'b100, 32'h12345678, 4'b0000, 5'd2, 0, t_last);
        waitResponse(0, 2'b00, bv);
        setIndex(4'd0);
        checkOutput("strb_zero_unchanged", dbgData, 32'hAA66AA88);
        checkOutput("strb_count", writeCount, 16'd5);
        checkOutput("strb_prot", lastAwprot, 3'b100);

        $display("[TB] error responses");
        applyStimulus(32'h40, 3'b111, 32'hFFFFFFFF, 4'hF, 5'd0, 0, t_last);
        waitResponse(0, 2'b11, bv);
        applyStimulus(32'h06, 3'b111, 32'hFFFFFFFF, 4'hF, 5'd0, 0, t_last);
        waitResponse(0, 2'b10, bv);
        applyStimulus(32'h3F, 3'b111, 32'hFFFFFFFF, 4'hF, 5'd3, 0, t_last);
        waitResponse(0, 2'b10, bv);
        checkOutput("err_count", writeCount, 16'd5);
        checkOutput("err_prot", lastAwprot, 3'b100);
        checkOutput("err_reg0", dbgData, 32'hAA66AA88);
        setIndex(4'd1);
        checkOutput("err_reg1", dbgData, 32'h11223344);
        setIndex(4'd15);
        checkOutput("err_reg15", dbgData, 32'h0);

        $display("[TB] B backpressure");
        applyStimulus(32'h0C, 3'b101, 32'hCAFEF00D, 4'hF, 5'd0, 0, t_last);
        waitResponse(10, 2'b00, bv);
        setIndex(4'd3);
        checkOutput("bp_reg3", dbgData, 32'hCAFEF00D);
        checkOutput("bp_count", writeCount, 16'd6);
        checkOutput("bp_prot", lastAwprot, 3'b101);

        $display("[TB] reset during delay");
        applyStimulus(32'h0C, 3'b001, 32'h12345678, 4'hF, 5'd10, 0, t_last);
        repeat (3) begin @(posedge aclk); #1; end
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("rst_bvalid", bvalid, 1'b0);
        checkOutput("rst_awready", awready, 1'b0);
        checkOutput("rst_count", writeCount, 16'd0);
        checkOutput("rst_prot", lastAwprot, 3'd0);
        checkOutput("rst_reg3", dbgData, 32'h0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (bvalid !== 1'b0) seen++;
        end
        checkOutput("rst_no_bvalid", seen, 0);

        $display("[TB] top-of-window write after reset");
        applyStimulus(32'h3C, 3'b110, 32'hA5A5A5A5, 4'hF, 5'd0, 0, t_last);
        waitResponse(0, 2'b00, bv);
        setIndex(4'd15);
        checkOutput("top_reg15", dbgData, 32'hA5A5A5A5);
        checkOutput("top_count", writeCount, 16'd1);
        checkOutput("top_prot", lastAwprot, 3'b110);

        repeat (3) @(posedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_write_slave_responder.md
Name: axi4_lite_write_slave_responder

Overview:
Synthesizable AXI4-Lite write-channel responder: the subordinate end of the write master's AW/W/B traffic. It accepts one address and one data beat independently, decodes the address against a configured window and commits byte-enabled data into a local register file. It then returns BRESP after a programmable delay. It is the DUT-side target for write-master sequences and also serves as a register-bank back end.

Parameters:
ADDRESS_WIDTH, 32, width of awaddr
DATA_WIDTH, 32, width of wdata (32 or 64); the byte-offset width ADDR_LSB = log2(DATA_WIDTH/8)
REG_COUNT, 16, number of DATA_WIDTH registers; must be a power of 2
MIN_ADDRESS, 32'h0000_0000, lowest decoded byte address
MAX_ADDRESS, 32'h0000_003F, highest decoded byte address; MAX_ADDRESS-MIN_ADDRESS+1 = REG_COUNT*DATA_WIDTH/8
DELAY_WIDTH, 5, width of the B-response delay input

Ports:
aclk  in  1  clock; all logic on the rising edge
areset  in  1  synchronous, active-high reset
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  ADDRESS_WIDTH  write byte address
awprot  in  3  protection attribute; captured but not decoded
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR; 01 EXOKAY is never generated
bvalidDelay  in  DELAY_WIDTH  idle cycles inserted before bvalid
dbgIndex  in  log2(REG_COUNT)  register-file read index
dbgData  out  DATA_WIDTH  combinational read of register[dbgIndex]
lastAwprot  out  3  awprot of the most recently committed write
writeCount  out  16  number of completed OKAY B handshakes; wraps modulo 2^16

Behaviour:
- Reset (areset=1 at an edge) values: awready=0, wready=0, bvalid=0, bresp=00, all registers=0, lastAwprot=0, writeCount=0, awCaptured=0, wCaptured=0, state=COLLECT, delay counter=0.
- Reset applies at the next edge from any state. An in-flight transaction is discarded: no commit and no bvalid.
- All outputs except dbgData are registered.
- States:
  - COLLECT: awready = !awCaptured, wready = !wCaptured (both 1 the cycle after reset releases).
  - An AW handshake (awvalid&&awready) latches awaddr and awprot, sets awCaptured and drops awready the next cycle.
  - A W handshake latches wdata and wstrb, sets wCaptured and drops wready.
  - AW and W may complete in the same cycle or in either order. A second beat on one channel is never accepted before the B handshake.
- COLLECT with awCaptured&&wCaptured (registered flags): in that cycle compute the response and commit at the edge, then:
  - if bvalidDelay==0, go to RESP;
  - otherwise load the counter with bvalidDelay and go to DELAY.
  - bvalidDelay is sampled only in this cycle.
- Decode, in priority order:
  - awaddr<MIN_ADDRESS or awaddr>MAX_ADDRESS gives DECERR;
  - otherwise, awaddr[ADDR_LSB-1:0]!=0 gives SLVERR;
  - otherwise OKAY.
- Commit (OKAY only): index = (awaddr-MIN_ADDRESS)>>ADDR_LSB. Byte lane i of register[index] is replaced by wdata lane i only when wstrb[i]=1. wstrb=0 is OKAY with no data change. lastAwprot is updated on an OKAY commit.
- Error responses leave the register file and lastAwprot unchanged.
- DELAY: the counter decrements each cycle; when it equals 1, go to RESP at that edge.
- RESP: bvalid=1 and bresp is held stable until bready.
  - On the B handshake at edge E: bvalid=0, both flags cleared, state=COLLECT. awready and wready are 1 in the cycle after E.
  - writeCount increments at E if bresp=OKAY.
- Latency: the last of AW/W handshakes at edge T gives bvalid=1 from T+2+bvalidDelay. Minimum turnaround from B handshake to the next AW acceptance is 1 cycle.
- awready and wready are 0 in DELAY and RESP. bvalid never asserts in COLLECT.

Test Plan:
- Single write: bvalidDelay=0, AW addr 0x08 and W data 0xDEADBEEF strb 0xF on the same edge T -> bvalid at T+2 with bresp=00; register[2]=0xDEADBEEF; writeCount=1.
- Independent channels: W (0x11223344, strb 0xF) 3 cycles before AW 0x04, bvalidDelay=4 -> wready low after its handshake, bvalid exactly 6 cycles after the AW edge, register[1]=0x11223344.
- Strobes: register[0]=0xAAAAAAAA, write 0x55667788 strb 0b0101 -> register[0]=0xAA66AA88; a following strb=0 write -> OKAY, value unchanged.
- Errors: awaddr 0x40 -> bresp=11; awaddr 0x06 -> bresp=10; register file and writeCount unchanged, lastAwprot unchanged.
- Backpressure: bready held low 10 cycles -> bvalid and bresp stable, awready and wready 0 throughout; the cycle after the handshake both readies are 1.
- Reset mid-operation: areset asserted during DELAY -> next edge all outputs at reset values, no bvalid, target register unchanged.
